// File: rtl/counter_seg7_pkg.sv
// rtl/counter_seg7_pkg.sv - shared constants and hex-to-segment table for the counter display
package counter_seg7_pkg;

  localparam int          CLK_HZ     = 100_000_000;
  localparam int          TICK_HZ    = 1;
  localparam int          SCAN_HZ    = 1000;
  localparam logic [31:0] LOAD_VALUE = 32'hFFFF_FFFF;
  localparam int          NUM_DIGITS = 8;

  // Bit 6 is CA, bit 0 is CG; a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = 7'b111_1111;
    case (nibble)
      4'h0: seg = 7'b000_0001;
      4'h1: seg = 7'b100_1111;
      4'h2: seg = 7'b001_0010;
      4'h3: seg = 7'b000_0110;
      4'h4: seg = 7'b100_1100;
      4'h5: seg = 7'b010_0100;
      4'h6: seg = 7'b010_0000;
      4'h7: seg = 7'b000_1111;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b000_0100;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b110_0000;
      4'hC: seg = 7'b011_0001;
      4'hD: seg = 7'b100_0010;
      4'hE: seg = 7'b011_0000;
      4'hF: seg = 7'b011_1000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/counter_seg7_clk_div.sv
// rtl/counter_seg7_clk_div.sv - divides the board clock to a 50% Clock_1Hz and a one-cycle tick
module counter_seg7_clk_div #(
  parameter int CLK_HZ  = counter_seg7_pkg::CLK_HZ,
  parameter int TICK_HZ = counter_seg7_pkg::TICK_HZ
) (
  input  logic Clock,
  input  logic Clear_n,
  output logic Clock_1Hz,
  output logic tick
);

  localparam int HALF   = CLK_HZ / (2 * TICK_HZ);
  localparam int DIV_CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DIV_CW-1:0] div;
  logic              clk_1hz_prev;

  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      div          <= '0;
      Clock_1Hz    <= 1'b0;
      clk_1hz_prev <= 1'b0;
    end else begin
      clk_1hz_prev <= Clock_1Hz;
      if (div == DIV_CW'(HALF - 1)) begin
        div       <= '0;
        Clock_1Hz <= ~Clock_1Hz;
      end else begin
        div <= div + DIV_CW'(1);
      end
    end
  end

  // Clock_1Hz is sampled as data only; its rising edge becomes a clock enable.
  assign tick = Clock_1Hz & ~clk_1hz_prev;

endmodule

// File: rtl/counter_seg7_counter.sv
// rtl/counter_seg7_counter.sv - 32-bit up/down loadable counter stepped by the divider tick
module counter_seg7_counter #(
  parameter logic [31:0] LOAD_VALUE = counter_seg7_pkg::LOAD_VALUE
) (
  input  logic        Clock,
  input  logic        Clear_n,
  input  logic        Load,
  input  logic        tick,
  input  logic        Enable,
  input  logic        Up_down,
  output logic [31:0] Count
);

  wire [31:0] Data = LOAD_VALUE;

  // Load is tested before Enable/Up_down so unknowns on those cannot reach Count.
  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      Count <= 32'h0000_0000;
    end else if (Load) begin
      Count <= Data;
    end else if (tick && Enable) begin
      if (Up_down) Count <= Count + 32'd1;
      else         Count <= Count - 32'd1;
    end
  end

endmodule

// File: rtl/counter_ffffffff_7_segment_led_top.sv
// rtl/counter_ffffffff_7_segment_led_top.sv - board top: hex counter with 8-digit multiplexed LED display
module counter_ffffffff_7_segment_led_top #(
  parameter int          CLK_HZ     = counter_seg7_pkg::CLK_HZ,
  parameter int          TICK_HZ    = counter_seg7_pkg::TICK_HZ,
  parameter int          SCAN_HZ    = counter_seg7_pkg::SCAN_HZ,
  parameter logic [31:0] LOAD_VALUE = counter_seg7_pkg::LOAD_VALUE
) (
  output logic AN7,
  output logic AN6,
  output logic AN5,
  output logic AN4,
  output logic AN3,
  output logic AN2,
  output logic AN1,
  output logic AN0,
  output logic CA,
  output logic CB,
  output logic CC,
  output logic CD,
  output logic CE,
  output logic CF,
  output logic CG,
  output logic DP,
  input  logic Enable,
  input  logic Up_down,
  input  logic Load,
  input  logic Clear_n,
  input  logic Clock
);

  import counter_seg7_pkg::*;

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SCAN_CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic                  Clock_1Hz;
  logic                  tick;
  logic [31:0]           Count;
  logic [SCAN_CW-1:0]    scan_cnt;
  logic [2:0]            digit_idx;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;

  counter_seg7_clk_div #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) clk_div_100MHz_to_1Hz_DUT (
    .Clock     (Clock),
    .Clear_n   (Clear_n),
    .Clock_1Hz (Clock_1Hz),
    .tick      (tick)
  );

  counter_seg7_counter #(
    .LOAD_VALUE (LOAD_VALUE)
  ) counter_DUT (
    .Clock   (Clock),
    .Clear_n (Clear_n),
    .Load    (Load),
    .tick    (tick),
    .Enable  (Enable),
    .Up_down (Up_down),
    .Count   (Count)
  );

  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
    end else if (scan_cnt == SCAN_CW'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_CW'(1);
    end
  end

  // Anode and cathodes share one register stage so a digit never shows its neighbour's pattern.
  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      an_q  <= '1;
      seg_q <= 7'b111_1111;
    end else begin
      an_q  <= ~(NUM_DIGITS'(1) << digit_idx);
      seg_q <= hex_to_seg(Count[{digit_idx, 2'b00} +: 4]);
    end
  end

  assign {AN7, AN6, AN5, AN4, AN3, AN2, AN1, AN0} = an_q;
  assign {CA, CB, CC, CD, CE, CF, CG}             = seg_q;
  assign DP                                       = 1'b1;

endmodule

// File: tb/tb_counter_ffffffff_7_segment_led_top.sv
// tb/tb_counter_ffffffff_7_segment_led_top.sv - directed self-checking bench for the counter display top
module tb_counter_ffffffff_7_segment_led_top;

  // Scaled timing: tick every 1000 cycles, Clock_1Hz half period 500, 10 cycles per digit.
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 1;
  localparam int SCAN_HZ = 100;

  localparam logic [6:0] SEG_0 = 7'b000_0001;
  localparam logic [6:0] SEG_1 = 7'b100_1111;
  localparam logic [6:0] SEG_F = 7'b011_1000;

  logic Clock = 1'b0;
  logic Clear_n;
  logic Enable;
  logic Up_down;
  logic Load;
  logic AN7, AN6, AN5, AN4, AN3, AN2, AN1, AN0;
  logic CA, CB, CC, CD, CE, CF, CG, DP;

  int n_assert = 0;
  int n_fail   = 0;
  int n        = 0;
  bit clk1_seen_high;

  wire [7:0]  an  = {AN7, AN6, AN5, AN4, AN3, AN2, AN1, AN0};
  wire [6:0]  seg = {CA, CB, CC, CD, CE, CF, CG};
  wire [31:0] cnt = dut.counter_DUT.Count;
  wire        clk1 = dut.clk_div_100MHz_to_1Hz_DUT.Clock_1Hz;

  counter_ffffffff_7_segment_led_top #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .SCAN_HZ    (SCAN_HZ),
    .LOAD_VALUE (32'hFFFF_FFFF)
  ) dut (
    .AN7 (AN7), .AN6 (AN6), .AN5 (AN5), .AN4 (AN4),
    .AN3 (AN3), .AN2 (AN2), .AN1 (AN1), .AN0 (AN0),
    .CA (CA), .CB (CB), .CC (CC), .CD (CD), .CE (CE), .CF (CF), .CG (CG),
    .DP (DP),
    .Enable  (Enable),
    .Up_down (Up_down),
    .Load    (Load),
    .Clear_n (Clear_n),
    .Clock   (Clock)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // n counts rising edges since the last reset release; sampling is on the falling edge.
  task automatic go(input int target);
    while (n < target) begin
      @(negedge Clock);
      n++;
    end
  endtask

  initial begin
    Clear_n = 1'b0;
    Load    = 1'b0;
    Enable  = 1'bx;
    Up_down = 1'bx;
    clk1_seen_high = 1'b0;

    for (int i = 1; i <= 400; i++) begin
      @(negedge Clock);
      if (clk1 !== 1'b0) clk1_seen_high = 1'b1;
      if (i == 5) begin
        check("reset_count", cnt, 32'h0);
        check("reset_an", {24'h0, an}, 32'hFF);
        check("reset_seg", {25'h0, seg}, 32'h7F);
      end
    end
    check("reset_clk1hz_low", {31'h0, clk1_seen_high}, 32'h0);
    check("reset_count_end", cnt, 32'h0);
    check("reset_dp", {31'h0, DP}, 32'h1);

    Clear_n = 1'b1;
    Load    = 1'b1;
    n = 0;
    go(1);
    check("load_immediate", cnt, 32'hFFFF_FFFF);
    check("scan_d0_an", {24'h0, an}, 32'hFE);
    go(11);
    check("scan_d1_an", {24'h0, an}, 32'hFD);
    check("scan_d1_seg_F", {25'h0, seg}, {25'h0, SEG_F});
    go(71);
    check("scan_d7_an", {24'h0, an}, 32'h7F);
    check("scan_d7_seg_F", {25'h0, seg}, {25'h0, SEG_F});
    go(81);
    check("scan_wrap_an", {24'h0, an}, 32'hFE);
    go(499);
    check("clk1hz_before_half", {31'h0, clk1}, 32'h0);
    go(500);
    check("clk1hz_rise_half", {31'h0, clk1}, 32'h1);
    go(1000);
    check("load_holds_over_tick", cnt, 32'hFFFF_FFFF);

    Load    = 1'b0;
    Enable  = 1'b1;
    Up_down = 1'b1;
    go(1500);
    check("up_before_tick", cnt, 32'hFFFF_FFFF);
    go(1501);
    check("up_wrap", cnt, 32'h0000_0000);
    go(2500);
    check("up_hold_between", cnt, 32'h0000_0000);
    go(2501);
    check("up_to_1", cnt, 32'h0000_0001);
    go(2561);
    check("disp1_d0_an", {24'h0, an}, 32'hFE);
    check("disp1_d0_seg", {25'h0, seg}, {25'h0, SEG_1});
    go(2571);
    check("disp1_d1_seg", {25'h0, seg}, {25'h0, SEG_0});

    go(3000);
    Up_down = 1'b0;
    go(3501);
    check("down_to_0", cnt, 32'h0000_0000);
    go(4501);
    check("down_wrap", cnt, 32'hFFFF_FFFF);
    go(4561);
    check("dispF_d0_seg", {25'h0, seg}, {25'h0, SEG_F});

    go(4600);
    Enable = 1'b0;
    go(6600);
    check("enable_off_hold", cnt, 32'hFFFF_FFFF);

    Enable  = 1'b1;
    Up_down = 1'b1;
    go(7501);
    check("reenable_up", cnt, 32'h0000_0000);
    go(8501);
    check("reenable_up2", cnt, 32'h0000_0001);
    go(8700);
    check("clk1hz_high_mid", {31'h0, clk1}, 32'h1);
    Clear_n = 1'b0;
    go(8701);
    check("midclear_count", cnt, 32'h0);
    check("midclear_an", {24'h0, an}, 32'hFF);
    check("midclear_seg", {25'h0, seg}, 32'h7F);
    check("midclear_clk1hz", {31'h0, clk1}, 32'h0);
    go(8705);

    Clear_n = 1'b1;
    n = 0;
    go(501);
    check("restart_first_step", cnt, 32'h0000_0001);
    go(1500);
    check("pre_load_tick", cnt, 32'h0000_0001);
    Load = 1'b1;
    go(1501);
    check("load_beats_tick", cnt, 32'hFFFF_FFFF);
    go(1510);
    check("load_hold_after", cnt, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
